// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: timer register map,
// CTRL bit positions, timer state encoding and the default peripheral base.
package data_mem_responder_pkg;

  localparam logic [31:0] PERIPH_BASE_DEFAULT = 32'hFFFF_0000;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_IRQ_EN      = 1;
  localparam int CTRL_AUTO_RELOAD = 2;

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } timer_state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// Core-side data bus: address/strobes/store data from the core, load data
// and the active-low interrupt back to it.
interface data_mem_responder_if;
  logic [31:0] memaddr;
  logic        memwrite;
  logic        memread;
  logic [3:0]  be;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        nIRQ;

  modport master (
    output memaddr, memwrite, memread, be, writedata,
    input  readdata, nIRQ
  );

  modport slave (
    input  memaddr, memwrite, memread, be, writedata,
    output readdata, nIRQ
  );
endinterface

// File: rtl/data_mem_responder_irq_timer.sv
// Memory-mapped countdown timer: CTRL/LOAD/COUNT/STATUS registers, a
// STOPPED/RUNNING FSM and a registered active-low interrupt output.
module irq_timer
  import data_mem_responder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [1:0]  wr_sel,
  input  logic [31:0] wr_data,
  input  logic [1:0]  rd_sel,
  output logic [31:0] rd_data,
  output logic        nirq
);

  timer_state_e state_p0, state_nxt;
  logic [2:0]   ctrl_p0, ctrl_nxt;
  logic [31:0]  load_p0, load_nxt;
  logic [31:0]  count_p0, count_nxt;
  logic         pending_p0, pending_nxt;
  logic         nirq_p0;
  logic         running;
  logic         expiry;

  // Next-state for the FSM and all timer registers; core writes override
  // the timer's own COUNT update, while expiry overrides a PENDING clear.
  always_comb begin
    state_nxt   = state_p0;
    ctrl_nxt    = ctrl_p0;
    load_nxt    = load_p0;
    count_nxt   = count_p0;
    pending_nxt = pending_p0;
    running     = (state_p0 == ST_RUNNING);
    expiry      = running && (count_p0 == 32'd0);

    if (expiry && !ctrl_p0[CTRL_AUTO_RELOAD]) ctrl_nxt[CTRL_EN] = 1'b0;
    if (wr_en && wr_sel == REG_CTRL) ctrl_nxt = wr_data[2:0];

    // Stopping (by write or one-shot expiry) freezes COUNT at its value.
    if (running && ctrl_nxt[CTRL_EN]) begin
      if (!expiry) count_nxt = count_p0 - 32'd1;
      else if (ctrl_p0[CTRL_AUTO_RELOAD]) count_nxt = load_p0;
    end
    if (wr_en && wr_sel == REG_LOAD) begin
      load_nxt  = wr_data;
      count_nxt = wr_data;
    end
    if (wr_en && wr_sel == REG_COUNT) count_nxt = wr_data;

    if (wr_en && wr_sel == REG_STATUS && wr_data[0]) pending_nxt = 1'b0;
    if (expiry) pending_nxt = 1'b1;

    case (state_p0)
      ST_STOPPED: if (ctrl_p0[CTRL_EN] && ctrl_nxt[CTRL_EN]) state_nxt = ST_RUNNING;
      ST_RUNNING: if (!ctrl_nxt[CTRL_EN]) state_nxt = ST_STOPPED;
      default:    state_nxt = ST_STOPPED;
    endcase
  end

  // Register update; the interrupt is registered from the current PENDING/IRQ_EN.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_p0   <= ST_STOPPED;
      ctrl_p0    <= 3'b000;
      load_p0    <= 32'd0;
      count_p0   <= 32'd0;
      pending_p0 <= 1'b0;
      nirq_p0    <= 1'b1;
    end else begin
      state_p0   <= state_nxt;
      ctrl_p0    <= ctrl_nxt;
      load_p0    <= load_nxt;
      count_p0   <= count_nxt;
      pending_p0 <= pending_nxt;
      nirq_p0    <= ~(pending_p0 & ctrl_p0[CTRL_IRQ_EN]);
    end
  end

  // Register read mux.
  always_comb begin
    rd_data = 32'd0;
    case (rd_sel)
      REG_CTRL:   rd_data = {29'd0, ctrl_p0};
      REG_LOAD:   rd_data = load_p0;
      REG_COUNT:  rd_data = count_p0;
      REG_STATUS: rd_data = {31'd0, pending_p0};
      default:    rd_data = 32'd0;
    endcase
  end

  assign nirq = nirq_p0;

endmodule

// File: rtl/data_mem_responder.sv
// Data-side responder beside a single-cycle core: word-addressed RAM with
// byte-lane writes, the interrupt timer block, and the address decode.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] PERIPH_BASE = PERIPH_BASE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0]           mem [DEPTH];
  logic                  ram_hit;
  logic                  periph_hit;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  timer_wr;
  logic [31:0]           timer_rdata;
  logic                  unused_addr_lsbs;

  assign ram_hit          = (bus.memaddr[31:ADDR_WIDTH+2] == '0);
  assign periph_hit       = (bus.memaddr[31:4] == PERIPH_BASE[31:4]);
  assign word_idx         = bus.memaddr[ADDR_WIDTH+1:2];
  assign timer_wr         = bus.memwrite && periph_hit;
  assign unused_addr_lsbs = ^bus.memaddr[1:0];

  // RAM byte-lane writes; the array itself is never reset, but writes are
  // suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (reset && bus.memwrite && ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.be[i]) mem[word_idx][8*i +: 8] <= bus.writedata[8*i +: 8];
      end
    end
  end

  // Zero-latency read path; unmapped addresses and memread=0 return zero.
  always_comb begin
    bus.readdata = 32'd0;
    if (bus.memread) begin
      if (ram_hit)         bus.readdata = mem[word_idx];
      else if (periph_hit) bus.readdata = timer_rdata;
    end
  end

  irq_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (timer_wr),
    .wr_sel  (bus.memaddr[3:2]),
    .wr_data (bus.writedata),
    .rd_sel  (bus.memaddr[3:2]),
    .rd_data (timer_rdata),
    .nirq    (bus.nIRQ)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: stimulus pushes expected readdata /
// nIRQ values into a scoreboard that a negedge monitor drains and compares.
module tb_data_mem_responder;

  localparam logic [31:0] A_CTRL   = 32'hFFFF_0000;
  localparam logic [31:0] A_LOAD   = 32'hFFFF_0004;
  localparam logic [31:0] A_COUNT  = 32'hFFFF_0008;
  localparam logic [31:0] A_STATUS = 32'hFFFF_000C;

  logic clk = 1'b0;
  logic reset;

  data_mem_responder_if bus();

  data_mem_responder #(
    .ADDR_WIDTH  (10),
    .PERIPH_BASE (32'hFFFF_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  string       sb_name[$];
  logic        sb_kind[$];
  logic [31:0] sb_exp[$];
  int          checks = 0;
  int          errors = 0;

  task automatic push(input string n, input logic k, input logic [31:0] v);
    sb_name.push_back(n);
    sb_kind.push_back(k);
    sb_exp.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic w, input logic r,
                       input logic [3:0] b, input logic [31:0] d);
    bus.memaddr   = a;
    bus.memwrite  = w;
    bus.memread   = r;
    bus.be        = b;
    bus.writedata = d;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    drive(a, 1'b1, 1'b0, b, d);
    tick();
    drive(a, 1'b0, 1'b0, 4'h0, 32'd0);
  endtask

  task automatic rd(input string n, input logic [31:0] a, input logic rden,
                    input logic [31:0] exp_d, input logic exp_irq);
    drive(a, 1'b0, rden, 4'h0, 32'd0);
    push(n, 1'b0, exp_d);
    push({n, ".nIRQ"}, 1'b1, {31'd0, exp_irq});
    tick();
  endtask

  task automatic idle();
    drive(32'd0, 1'b0, 1'b0, 4'h0, 32'd0);
    tick();
  endtask

  // Scoreboard monitor: everything queued during a cycle is checked at its negedge.
  always @(negedge clk) begin
    while (sb_name.size() > 0) begin
      string       n;
      logic        k;
      logic [31:0] e;
      logic [31:0] a;
      n = sb_name.pop_front();
      k = sb_kind.pop_front();
      e = sb_exp.pop_front();
      a = k ? {31'd0, bus.nIRQ} : bus.readdata;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %h, expected %h", n, a, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    drive(32'd0, 1'b0, 1'b0, 4'h0, 32'd0);
    tick();
    tick();
    rd("rst_ctrl",   A_CTRL,   1'b1, 32'd0, 1'b1);
    rd("rst_count",  A_COUNT,  1'b1, 32'd0, 1'b1);
    reset = 1'b1;
    idle();

    // RAM: byte lanes, same-cycle read, be=0, range boundaries, gating
    wr(32'h10, 32'hAABB_CCDD, 4'b1111);
    wr(32'h10, 32'h1122_3344, 4'b0101);
    rd("byte_lanes", 32'h10, 1'b1, 32'hAA22_CC44, 1'b1);
    wr(32'h14, 32'h1234_5678, 4'b1111);
    drive(32'h14, 1'b1, 1'b1, 4'b1111, 32'h8765_4321);
    push("rw_old_value", 1'b0, 32'h1234_5678);
    tick();
    rd("rw_new_value", 32'h14, 1'b1, 32'h8765_4321, 1'b1);
    wr(32'h14, 32'hFFFF_FFFF, 4'b0000);
    rd("be_zero_noop", 32'h14, 1'b1, 32'h8765_4321, 1'b1);
    wr(32'h0, 32'h5A5A_5A5A, 4'b1111);
    wr(32'h8000_0000, 32'hDEAD_BEEF, 4'b1111);
    rd("oor_read",     32'h8000_0000, 1'b1, 32'd0, 1'b1);
    rd("oor_no_alias", 32'h0,         1'b1, 32'h5A5A_5A5A, 1'b1);
    wr(32'hFFC, 32'hCAFE_F00D, 4'b1111);
    rd("ram_last_word", 32'hFFC,       1'b1, 32'hCAFE_F00D, 1'b1);
    rd("ram_past_end",  32'h1000,      1'b1, 32'd0, 1'b1);
    rd("periph_hole",   32'hFFFF_0010, 1'b1, 32'd0, 1'b1);
    rd("memread_gate",  32'h10,        1'b0, 32'd0, 1'b1);

    // One-shot: LOAD=3, EN|IRQ_EN
    wr(A_LOAD, 32'd3, 4'hF);
    wr(A_CTRL, 32'd3, 4'hF);
    rd("os_cnt_a", A_COUNT, 1'b1, 32'd3, 1'b1);
    rd("os_cnt_b", A_COUNT, 1'b1, 32'd3, 1'b1);
    rd("os_cnt_c", A_COUNT, 1'b1, 32'd2, 1'b1);
    rd("os_cnt_d", A_COUNT, 1'b1, 32'd1, 1'b1);
    rd("os_cnt_e", A_COUNT, 1'b1, 32'd0, 1'b1);
    rd("os_pending", A_STATUS, 1'b1, 32'd1, 1'b1);
    rd("os_en_clr",  A_CTRL,   1'b1, 32'd2, 1'b0);
    rd("os_cnt_hold", A_COUNT, 1'b1, 32'd0, 1'b0);
    wr(A_STATUS, 32'd1, 4'hF);
    rd("os_clr_a", A_STATUS, 1'b1, 32'd0, 1'b0);
    rd("os_clr_b", A_STATUS, 1'b1, 32'd0, 1'b1);

    // Auto-reload: LOAD=2, period 3; W1C on an expiry edge loses
    wr(A_LOAD, 32'd2, 4'hF);
    wr(A_CTRL, 32'd7, 4'hF);
    rd("ar_0", A_COUNT, 1'b1, 32'd2, 1'b1);
    rd("ar_1", A_COUNT, 1'b1, 32'd2, 1'b1);
    rd("ar_2", A_COUNT, 1'b1, 32'd1, 1'b1);
    rd("ar_3", A_COUNT, 1'b1, 32'd0, 1'b1);
    rd("ar_4", A_COUNT, 1'b1, 32'd2, 1'b1);
    rd("ar_5", A_COUNT, 1'b1, 32'd1, 1'b0);
    rd("ar_6", A_COUNT, 1'b1, 32'd0, 1'b0);
    rd("ar_7", A_COUNT, 1'b1, 32'd2, 1'b0);
    rd("ar_8", A_COUNT, 1'b1, 32'd1, 1'b0);
    wr(A_STATUS, 32'd1, 4'hF);
    rd("ar_w1c_lose", A_STATUS, 1'b1, 32'd1, 1'b0);
    wr(A_CTRL, 32'd0, 4'hF);
    rd("stop_freeze_a", A_COUNT, 1'b1, 32'd1, 1'b0);
    rd("stop_freeze_b", A_COUNT, 1'b1, 32'd1, 1'b1);
    rd("stop_pending",  A_STATUS, 1'b1, 32'd1, 1'b1);
    wr(A_STATUS, 32'd1, 4'hF);
    rd("w1c_ok", A_STATUS, 1'b1, 32'd0, 1'b1);

    // IRQ masking: expire with IRQ_EN=0, then unmask
    wr(A_LOAD, 32'd1, 4'hF);
    wr(A_CTRL, 32'd1, 4'hF);
    rd("mask_a", A_STATUS, 1'b1, 32'd0, 1'b1);
    rd("mask_b", A_STATUS, 1'b1, 32'd0, 1'b1);
    rd("mask_c", A_STATUS, 1'b1, 32'd0, 1'b1);
    rd("mask_d", A_STATUS, 1'b1, 32'd1, 1'b1);
    rd("mask_e", A_STATUS, 1'b1, 32'd1, 1'b1);
    wr(A_CTRL, 32'd2, 4'hF);
    rd("unmask_a", A_STATUS, 1'b1, 32'd1, 1'b1);
    rd("unmask_b", A_STATUS, 1'b1, 32'd1, 1'b0);
    wr(A_STATUS, 32'd1, 4'hF);
    idle();

    // COUNT write on the expiry edge wins over reload; PENDING still sets
    wr(A_CTRL, 32'd5, 4'hF);
    idle();
    wr(A_COUNT, 32'd9, 4'hF);
    rd("exp_wr_count", A_COUNT,  1'b1, 32'd9, 1'b1);
    rd("exp_wr_pend",  A_STATUS, 1'b1, 32'd1, 1'b1);
    rd("exp_wr_run",   A_COUNT,  1'b1, 32'd7, 1'b1);

    // Reset mid-operation, with a RAM write attempted during reset
    wr(A_CTRL, 32'd3, 4'hF);
    wr(A_COUNT, 32'd100, 4'hF);
    rd("pre_rst_pend",  A_STATUS, 1'b1, 32'd1, 1'b0);
    rd("pre_rst_count", A_COUNT,  1'b1, 32'd99, 1'b0);
    reset = 1'b0;
    drive(32'h10, 1'b1, 1'b0, 4'hF, 32'h0);
    tick();
    reset = 1'b1;
    rd("mid_rst_ctrl",   A_CTRL,   1'b1, 32'd0, 1'b1);
    rd("mid_rst_load",   A_LOAD,   1'b1, 32'd0, 1'b1);
    rd("mid_rst_count",  A_COUNT,  1'b1, 32'd0, 1'b1);
    rd("mid_rst_status", A_STATUS, 1'b1, 32'd0, 1'b1);
    rd("mid_rst_ram",    32'h10,   1'b1, 32'hAA22_CC44, 1'b1);

    idle();
    idle();
    checks++;
    if (sb_name.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_name.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
